seg7_to_bcd_monitor: RTL and testbench
======================================

# seg7_to_bcd_monitor

Read-back monitor for multiplexed-free 7-segment display buses: samples NUM_DIGITS active-low segment patterns, requires each to be stable for STABLE_CYCLES scan visits, and converts them back to BCD digits with valid/blank/error status. It is the inverse of the display decoder path. It sits beside the timer's display outputs so that self-check logic and the testbench can read the displayed time as numbers. One shared pattern-to-digit converter is time-multiplexed across digits by a round-robin scan counter.

## Interface
- NUM_DIGITS, 6, number of displays monitored (1..8)
- STABLE_CYCLES, 4, consecutive identical visits needed to accept a pattern (2..15)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- en  in  1  scan enable; low freezes all state
- hex_in  in  7*NUM_DIGITS  digit k in bits [7k+6:7k]; bit 7k+6 = segment a … bit 7k = segment g; active-low (0 = lit)
- err_clr  in  1  clears all sticky error bits
- bcd_out  out  4*NUM_DIGITS  accepted digit k in [4k+3:4k]
- digit_valid  out  NUM_DIGITS  accepted pattern is 0–9
- blank  out  NUM_DIGITS  accepted pattern is all-off (7'b1111111)
- err  out  NUM_DIGITS  sticky: an unrecognised pattern was accepted
- update  out  1  one-cycle pulse: an accepted digit changed value/status
- pass_done  out  1  one-cycle pulse: scan index wrapped NUM_DIGITS-1 → 0

## Operation
- Scan index idx: 0..NUM_DIGITS-1, +1 per cycle while en=1, wraps to 0.
- Per-digit state: last_pat (7 b), cnt (saturating 0..STABLE_CYCLES), accepted bcd/valid/blank.
- On visit of digit k, p = hex_in slice k:
  - p != last_pat: last_pat←p, cnt←1.
  - p == last_pat and cnt < STABLE_CYCLES: cnt←cnt+1.
  - Acceptance occurs on the visit where cnt becomes STABLE_CYCLES; no re-acceptance while saturated.
- Decode on accept (shared converter, patterns a..g):
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9: bcd=digit, valid=1, blank=0.
  - 1111111: bcd=4'hF, valid=0, blank=1.
  - Any other pattern: bcd=4'hE, valid=0, blank=0, err[k]←1.
- update=1 only if the accepted {bcd,valid,blank} differs from the stored value for k.
- err_clr clears all err bits; if err_clr coincides with a new error accept on digit k, err[k] ends at 1 (set wins).
- en=0: idx, last_pat, cnt and accepted values hold; update=0, pass_done=0. err_clr is still honoured.

## Timing
- Reset values: idx=0, last_pat=7'b1111111, cnt=0, bcd_out all 4'hF, digit_valid=0, blank=0, err=0, update=0, pass_done=0.
- All outputs are registered; new bcd/valid/blank and update become visible together in the cycle after the accepting visit's clock edge.
- Worst-case latency from a pattern becoming stable to its acceptance: NUM_DIGITS*STABLE_CYCLES cycles (+1 to register), en held high.
- Glitches shorter than STABLE_CYCLES visits never change outputs. A glitch that occurs mid-count restarts cnt at 1.
- Because of its reset value, an initially blank digit is accepted after STABLE_CYCLES visits, which pulses update (blank 0→1).
- Reset mid-scan returns everything to reset values on the next edge, including any pending count.

## Structure
- Package seg7_pkg: SEG_0..SEG_9 and SEG_BLANK pattern constants, BCD_BLANK=4'hF, BCD_ERR=4'hE. This package is shared with the display decoder.
- Sub-module seg7_to_bin: combinational, 7-bit pattern → {valid, blank, bin[3:0]}; instantiated once.
- Top module: scan counter, per-digit register arrays, accept/compare logic.

## Test plan
- Reset: hold rst_n=0 for 3 cycles → bcd_out=24'hFFFFFF, all flags 0, no pulses. Release with all hex_in=1111111 → within 25 cycles blank=6'b111111, 6 update pulses.
- All digits 0000001 (“0”), stable → within 25 cycles digit_valid=6'b111111, bcd_out=0. pass_done fires every 6 cycles.
- Digit 2 is stable at 0010010 (2). Drive 0000110 for 2 visits, then revert → bcd digit 2 stays 2, no update. Hold 0000110 for 4 visits → digit 2 = 3, one update.
- Digit 5 = 1111110, stable → bcd[23:20]=4'hE, valid[5]=0, err[5]=1. Pulse err_clr → err=0. err_clr coinciding with the accept → err[5]=1.
- en=0 for 10 cycles while hex_in changes → outputs and idx frozen, no pulses. Re-enable → acceptance resumes from the held idx.
- Assert rst_n=0 while digit 1 is mid-count (cnt=2) → all reset values next cycle. After release, a full STABLE_CYCLES visits are needed before acceptance.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment pattern definitions (active-low, bit 6 = segment a ... bit 0 = segment g).
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_ERR   = 4'hE;

  // Decoded status of one digit as held by the monitor.
  typedef struct packed {
    logic       valid;
    logic       blank;
    logic [3:0] bin;
  } seg7_dec_t;

endpackage

// File: rtl/seg7_to_bin.sv
// Combinational 7-segment pattern to binary converter with blank/valid status.
module seg7_to_bin
  import seg7_pkg::*;
(
  input  logic [6:0] pat,
  output logic       valid,
  output logic       blank,
  output logic [3:0] bin
);

  // Map a recognised pattern to its digit; blank and unknown patterns get marker codes.
  always_comb begin
    valid = 1'b1;
    blank = 1'b0;
    bin   = '0;
    case (pat)
      SEG_0: bin = 4'd0;
      SEG_1: bin = 4'd1;
      SEG_2: bin = 4'd2;
      SEG_3: bin = 4'd3;
      SEG_4: bin = 4'd4;
      SEG_5: bin = 4'd5;
      SEG_6: bin = 4'd6;
      SEG_7: bin = 4'd7;
      SEG_8: bin = 4'd8;
      SEG_9: bin = 4'd9;
      SEG_BLANK: begin
        valid = 1'b0;
        blank = 1'b1;
        bin   = BCD_BLANK;
      end
      default: begin
        valid = 1'b0;
        bin   = BCD_ERR;
      end
    endcase
  end

endmodule

// File: rtl/seg7_to_bcd_monitor.sv
// Scans NUM_DIGITS segment patterns round-robin, debounces each over STABLE_CYCLES
// visits and reports the accepted digits as BCD with valid/blank/sticky-error status.
module seg7_to_bcd_monitor
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 6,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [7*NUM_DIGITS-1:0] hex_in,
  input  logic                    err_clr,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic [NUM_DIGITS-1:0]   err,
  output logic                    update,
  output logic                    pass_done
);

  localparam int         IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [3:0] CNT_MAX  = 4'(STABLE_CYCLES);
  localparam logic [3:0] CNT_LAST = 4'(STABLE_CYCLES - 1);

  logic [IW-1:0] idx;
  logic [6:0]    last_pat [NUM_DIGITS];
  logic [3:0]    cnt      [NUM_DIGITS];

  logic [6:0]          pat;
  logic [6:0]          cur_last;
  logic [3:0]          cur_cnt;
  seg7_dec_t           cur_acc;
  seg7_dec_t           dec;
  logic                dec_valid;
  logic                dec_blank;
  logic [3:0]          dec_bin;
  logic                same;
  logic                accept;
  logic                changed;
  logic                idx_last;
  logic [NUM_DIGITS-1:0] err_set;

  // Select the visited digit's input slice and stored state for the shared converter.
  always_comb begin
    pat      = SEG_BLANK;
    cur_last = SEG_BLANK;
    cur_cnt  = '0;
    cur_acc  = '{valid: 1'b0, blank: 1'b0, bin: BCD_BLANK};
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        pat      = hex_in[7*k +: 7];
        cur_last = last_pat[k];
        cur_cnt  = cnt[k];
        cur_acc  = '{valid: digit_valid[k], blank: blank[k], bin: bcd_out[4*k +: 4]};
      end
    end
  end

  seg7_to_bin u_conv (
    .pat   (pat),
    .valid (dec_valid),
    .blank (dec_blank),
    .bin   (dec_bin)
  );

  // Acceptance fires only on the visit that brings the count up to STABLE_CYCLES.
  always_comb begin
    dec      = '{valid: dec_valid, blank: dec_blank, bin: dec_bin};
    same     = (pat == cur_last);
    accept   = en && same && (cur_cnt == CNT_LAST);
    changed  = (dec != cur_acc);
    idx_last = (idx == IW'(NUM_DIGITS - 1));
    err_set  = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k) && accept && !dec_valid && !dec_blank) begin
        err_set[k] = 1'b1;
      end
    end
  end

  // Scan counter, per-digit debounce state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx         <= '0;
      bcd_out     <= '1;
      digit_valid <= '0;
      blank       <= '0;
      err         <= '0;
      update      <= 1'b0;
      pass_done   <= 1'b0;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        last_pat[k] <= SEG_BLANK;
        cnt[k]      <= '0;
      end
    end else begin
      update    <= 1'b0;
      pass_done <= 1'b0;
      // A new error accept overrides a simultaneous clear.
      err       <= (err_clr ? '0 : err) | err_set;
      if (en) begin
        idx       <= idx_last ? '0 : idx + 1'b1;
        pass_done <= idx_last;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
          if (idx == IW'(k)) begin
            if (!same) begin
              last_pat[k] <= pat;
              cnt[k]      <= 4'd1;
            end else if (cnt[k] < CNT_MAX) begin
              cnt[k] <= cnt[k] + 4'd1;
            end
            if (accept) begin
              bcd_out[4*k +: 4] <= dec_bin;
              digit_valid[k]    <= dec_valid;
              blank[k]          <= dec_blank;
              update            <= changed;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_to_bcd_monitor.sv
// Randomised and directed bench for seg7_to_bcd_monitor against a behavioural model.
module tb_seg7_to_bcd_monitor;

  localparam int N = 6;
  localparam int S = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b1;
  logic [7*N-1:0] hex_in = '1;
  logic           err_clr = 1'b0;
  logic [4*N-1:0] bcd_out;
  logic [N-1:0]   digit_valid;
  logic [N-1:0]   blank;
  logic [N-1:0]   err;
  logic           update;
  logic           pass_done;

  seg7_to_bcd_monitor #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .hex_in      (hex_in),
    .err_clr     (err_clr),
    .bcd_out     (bcd_out),
    .digit_valid (digit_valid),
    .blank       (blank),
    .err         (err),
    .update      (update),
    .pass_done   (pass_done)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference model state
  int         m_idx;
  logic [6:0] m_last [N];
  int         m_cnt  [N];
  logic [3:0] m_bcd  [N];
  bit         m_val  [N];
  bit         m_blk  [N];
  bit         m_err  [N];
  bit         m_upd, m_pass;

  function automatic void mdecode(input logic [6:0] p, output logic [3:0] b, output bit v, output bit bl);
    b = 4'hE; v = 0; bl = 0;
    if (p == 7'h7F) begin b = 4'hF; bl = 1; end
    for (int d = 0; d < 10; d++) if (p == seg_tab[d]) begin b = 4'(d); v = 1; end
  endfunction

  task automatic model_reset();
    m_idx = 0; m_upd = 0; m_pass = 0;
    for (int k = 0; k < N; k++) begin
      m_last[k] = 7'h7F; m_cnt[k] = 0; m_bcd[k] = 4'hF;
      m_val[k] = 0; m_blk[k] = 0; m_err[k] = 0;
    end
  endtask

  task automatic model_step();
    logic [6:0] p;
    logic [3:0] b;
    bit v, bl;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_upd = 0; m_pass = 0;
    if (err_clr) for (int k = 0; k < N; k++) m_err[k] = 0;
    if (en) begin
      p = hex_in[7*m_idx +: 7];
      if (p != m_last[m_idx]) begin
        m_last[m_idx] = p; m_cnt[m_idx] = 1;
      end else if (m_cnt[m_idx] < S) begin
        m_cnt[m_idx]++;
        if (m_cnt[m_idx] == S) begin
          mdecode(p, b, v, bl);
          if (b != m_bcd[m_idx] || v != m_val[m_idx] || bl != m_blk[m_idx]) m_upd = 1;
          m_bcd[m_idx] = b; m_val[m_idx] = v; m_blk[m_idx] = bl;
          if (!v && !bl) m_err[m_idx] = 1;
        end
      end
      m_pass = (m_idx == N - 1);
      m_idx = (m_idx + 1) % N;
    end
  endtask

  int n_upd = 0;
  int n_pd = 0;

  task automatic tick();
    logic [4*N-1:0] eb;
    logic [N-1:0] ev, ebl, ee;
    @(posedge clk);
    model_step();
    #1;
    for (int k = 0; k < N; k++) begin
      eb[4*k +: 4] = m_bcd[k]; ev[k] = m_val[k]; ebl[k] = m_blk[k]; ee[k] = m_err[k];
    end
    check("bcd_out", 64'(bcd_out), 64'(eb));
    check("digit_valid", 64'(digit_valid), 64'(ev));
    check("blank", 64'(blank), 64'(ebl));
    check("err", 64'(err), 64'(ee));
    check("update", 64'(update), 64'(m_upd));
    check("pass_done", 64'(pass_done), 64'(m_pass));
    if (update) n_upd++;
    if (pass_done) n_pd++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_digit(input int k, input logic [6:0] p);
    hex_in[7*k +: 7] = p;
  endtask

  function automatic logic [6:0] rand_pat();
    int r;
    logic [6:0] p;
    r = $urandom_range(0, 11);
    if (r < 10) p = seg_tab[r];
    else if (r == 10) p = 7'h7F;
    else p = 7'($urandom);
    return p;
  endfunction

  int err_hi;
  bit reached;

  initial begin
    model_reset();
    // Reset held for three cycles
    rst_n = 0;
    ticks(3);
    check("rst_bcd", 64'(bcd_out), 64'h00FFFFFF);
    check("rst_flags", 64'({digit_valid, blank, err, update, pass_done}), 64'd0);

    // All blank after release
    rst_n = 1; n_upd = 0;
    ticks(25);
    check("blank_all", 64'(blank), 64'h3F);
    check("blank_updates", 64'(n_upd), 64'd6);

    // All zero
    for (int k = 0; k < N; k++) set_digit(k, 7'b0000001);
    ticks(25);
    check("zero_valid", 64'(digit_valid), 64'h3F);
    check("zero_bcd", 64'(bcd_out), 64'd0);
    n_pd = 0;
    ticks(12);
    check("pass_done_rate", 64'(n_pd), 64'd2);

    // Glitch on digit 2 shorter than the stable window
    set_digit(2, 7'b0010010);
    ticks(30);
    check("d2_is_2", 64'(bcd_out[11:8]), 64'd2);
    n_upd = 0;
    set_digit(2, 7'b0000110);
    ticks(12);
    set_digit(2, 7'b0010010);
    ticks(30);
    check("d2_glitch_hold", 64'(bcd_out[11:8]), 64'd2);
    check("d2_glitch_noupd", 64'(n_upd), 64'd0);
    set_digit(2, 7'b0000110);
    ticks(30);
    check("d2_is_3", 64'(bcd_out[11:8]), 64'd3);
    check("d2_one_upd", 64'(n_upd), 64'd1);

    // Unrecognised pattern on digit 5, clear, then clear colliding with accept
    set_digit(5, 7'b1111110);
    ticks(30);
    check("d5_bcd_err", 64'(bcd_out[23:20]), 64'hE);
    check("d5_invalid", 64'(digit_valid[5]), 64'd0);
    check("d5_err_set", 64'(err[5]), 64'd1);
    err_clr = 1;
    tick();
    err_clr = 0;
    check("err_cleared", 64'(err), 64'd0);
    set_digit(5, 7'b1111101);
    err_clr = 1; err_hi = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (err[5]) err_hi++;
    end
    err_clr = 0;
    check("err_set_wins", 64'(err_hi), 64'd1);

    // Freeze with en low while inputs move
    en = 0; n_upd = 0; n_pd = 0;
    for (int i = 0; i < 10; i++) begin
      set_digit($urandom_range(0, N - 1), rand_pat());
      tick();
    end
    check("frozen_pulses", 64'(n_upd + n_pd), 64'd0);
    en = 1;
    for (int k = 0; k < N; k++) set_digit(k, seg_tab[k]);
    ticks(30);
    check("resume_d4", 64'(bcd_out[19:16]), 64'd4);

    // Reset while digit 1 is mid-count
    set_digit(1, 7'b0001111);
    reached = 0;
    for (int i = 0; i < 20 && !reached; i++) begin
      tick();
      if (m_cnt[1] == 2) reached = 1;
    end
    check("midcount_reached", 64'(reached), 64'd1);
    rst_n = 0;
    tick();
    check("midrst_bcd", 64'(bcd_out), 64'h00FFFFFF);
    check("midrst_valid", 64'(digit_valid), 64'd0);
    rst_n = 1;
    ticks(30);
    check("post_rst_d1", 64'(bcd_out[7:4]), 64'd7);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < N; k++) if ($urandom_range(0, 39) == 0) set_digit(k, rand_pat());
      en = ($urandom_range(0, 9) != 0);
      err_clr = ($urandom_range(0, 19) == 0);
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst_n = 1; en = 1; err_clr = 0;
    ticks(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
